// File: rtl/rsa256_wrapper.sv
// rsa256_wrapper: bridges an Avalon-MM RS232 UART to a 256-bit RSA core.
// Loads a 32-byte key once, then per 32-byte data block runs the core and returns 31 result bytes.
module rsa256_wrapper (
  input  logic         i_clk,
  input  logic         i_rst_n,
  output logic [4:0]   avm_address,
  output logic         avm_read,
  input  logic [31:0]  avm_readdata,
  output logic         avm_write,
  output logic [31:0]  avm_writedata,
  input  logic         avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_b,
  input  logic         i_core_finished,
  input  logic [255:0] i_core_result
);

  localparam logic [4:0] ADDR_RX     = 5'd0;
  localparam logic [4:0] ADDR_TX     = 5'd4;
  localparam logic [4:0] ADDR_STATUS = 5'd8;
  localparam logic [4:0] LAST_RX     = 5'd31;
  localparam logic [4:0] LAST_TX     = 5'd30;

  typedef enum logic [2:0] {
    S_QRX   = 3'd0,
    S_RX    = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_QTX   = 3'd4,
    S_TX    = 3'd5
  } state_t;

  state_t         state_r, state_s;
  logic [4:0]     cnt_r, cnt_s;
  logic           key_loaded_r, key_loaded_s;
  logic [255:0]   a_r, a_s;
  logic [255:0]   b_r, b_s;
  logic [247:0]   tx_r, tx_s;
  logic [4:0]     addr_r, addr_s;
  logic           read_r, read_s;
  logic           write_r, write_s;
  logic [7:0]     wbyte_r, wbyte_s;
  logic           start_r, start_s;
  logic           rd_done_s;
  logic           wr_done_s;
  logic           unused_s;

  // A transfer completes in the first cycle its request is seen with no stall.
  assign rd_done_s = read_r & ~avm_waitrequest;
  assign wr_done_s = write_r & ~avm_waitrequest;

  // Result byte 31 (bits [255:248]) is never transmitted; upper UART bits carry nothing.
  assign unused_s = ^{avm_readdata[31:8], i_core_result[255:248]};

  // Next-state, byte counter and data-path register updates.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    key_loaded_s = key_loaded_r;
    a_s          = a_r;
    b_s          = b_r;
    tx_s         = tx_r;
    case (state_r)
      S_QRX: begin
        if (rd_done_s && avm_readdata[7]) begin
          state_s = S_RX;
        end else begin
          state_s = S_QRX;
        end
      end
      S_RX: begin
        if (rd_done_s) begin
          if (key_loaded_r) begin
            b_s = {b_r[247:0], avm_readdata[7:0]};
          end else begin
            a_s = {a_r[247:0], avm_readdata[7:0]};
          end
          if (cnt_r == LAST_RX) begin
            cnt_s = 5'd0;
            if (key_loaded_r) begin
              state_s = S_START;
            end else begin
              key_loaded_s = 1'b1;
              state_s      = S_QRX;
            end
          end else begin
            cnt_s   = cnt_r + 5'd1;
            state_s = S_QRX;
          end
        end else begin
          state_s = S_RX;
        end
      end
      S_START: begin
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (i_core_finished) begin
          tx_s    = i_core_result[247:0];
          state_s = S_QTX;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_QTX: begin
        if (rd_done_s && avm_readdata[6]) begin
          state_s = S_TX;
        end else begin
          state_s = S_QTX;
        end
      end
      S_TX: begin
        if (wr_done_s) begin
          tx_s = {tx_r[239:0], 8'h00};
          if (cnt_r == LAST_TX) begin
            cnt_s   = 5'd0;
            state_s = S_QRX;
          end else begin
            cnt_s   = cnt_r + 5'd1;
            state_s = S_QTX;
          end
        end else begin
          state_s = S_TX;
        end
      end
      default: begin
        state_s = S_QRX;
      end
    endcase
  end

  // Bus and core-control outputs follow the next state so they can be registered.
  always_comb begin
    read_s  = 1'b0;
    write_s = 1'b0;
    addr_s  = ADDR_STATUS;
    wbyte_s = 8'h00;
    start_s = 1'b0;
    case (state_s)
      S_QRX, S_QTX: begin
        read_s = 1'b1;
      end
      S_RX: begin
        read_s = 1'b1;
        addr_s = ADDR_RX;
      end
      S_TX: begin
        write_s = 1'b1;
        addr_s  = ADDR_TX;
        wbyte_s = tx_s[247:240];
      end
      S_START: begin
        start_s = 1'b1;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r      <= S_QRX;
      cnt_r        <= 5'd0;
      key_loaded_r <= 1'b0;
      a_r          <= 256'd0;
      b_r          <= 256'd0;
      tx_r         <= 248'd0;
      addr_r       <= ADDR_STATUS;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      wbyte_r      <= 8'h00;
      start_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      key_loaded_r <= key_loaded_s;
      a_r          <= a_s;
      b_r          <= b_s;
      tx_r         <= tx_s;
      addr_r       <= addr_s;
      read_r       <= read_s;
      write_r      <= write_s;
      wbyte_r      <= wbyte_s;
      start_r      <= start_s;
    end
  end

  assign avm_address   = addr_r;
  assign avm_read      = read_r;
  assign avm_write     = write_r;
  assign avm_writedata = {24'h000000, wbyte_r};
  assign o_core_start  = start_r;
  assign o_core_a      = a_r;
  assign o_core_b      = b_r;

endmodule

// File: tb/tb_rsa256_wrapper.sv
// tb_rsa256_wrapper: UART slave and RSA core models around rsa256_wrapper;
// expected TX bytes are queued when the core result is driven and popped on each UART write.
module tb_rsa256_wrapper;

  localparam logic [255:0] CORE_RES = 256'h00112233445566778899AABBCCDDEEFF;
  localparam int CORE_LAT = 10;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [4:0]   avm_address;
  logic         avm_read;
  logic [31:0]  avm_readdata;
  logic         avm_write;
  logic [31:0]  avm_writedata;
  logic         avm_waitrequest;
  logic         o_core_start;
  logic [255:0] o_core_a;
  logic [255:0] o_core_b;
  logic         i_core_finished;
  logic [255:0] i_core_result;

  always #5 clk = ~clk;

  rsa256_wrapper dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .o_core_start    (o_core_start),
    .o_core_a        (o_core_a),
    .o_core_b        (o_core_b),
    .i_core_finished (i_core_finished),
    .i_core_result   (i_core_result)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Shared model state
  logic       rst_q = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] tx_log[$];
  int rx_done = 0, tx_done = 0, starts = 0;
  int wait_cycles = 0, rx_delay = 0, tx_delay = 0;

  always @(posedge clk) rst_q <= i_rst_n;

  // UART slave: optional stall per transfer, status gating, protocol checks.
  initial begin
    int polls, wcnt;
    logic rx_gr, tx_gr, pend, hold, prev_start;
    logic p_rd, p_wr;
    logic [4:0] p_addr;
    logic [31:0] p_wdata, p_rdata;
    logic [38:0] held;
    polls = 0; wcnt = 0; rx_gr = 1'b0; tx_gr = 1'b0; pend = 1'b0; hold = 1'b0;
    prev_start = 1'b0; held = '0;
    p_rd = 1'b0; p_wr = 1'b0; p_addr = 5'd0; p_wdata = 32'h0; p_rdata = 32'h0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_q) begin
        rx_q.delete();
        hold = 1'b0; wcnt = 0; rx_gr = 1'b0; tx_gr = 1'b0; polls = 0;
      end else if (pend) begin
        if (p_rd && p_addr == 5'd8) begin
          rx_gr = p_rdata[7];
          tx_gr = p_rdata[6];
          polls++;
        end else if (p_rd && p_addr == 5'd0) begin
          chk("rx_gate", 256'(rx_gr), 256'(1));
          chk("rx_avail", 256'(rx_q.size() > 0), 256'(1));
          if (rx_q.size() > 0) void'(rx_q.pop_front());
          rx_gr = 1'b0; polls = 0; rx_done++;
        end else if (p_wr && p_addr == 5'd4) begin
          chk("tx_gate", 256'(tx_gr), 256'(1));
          chk("tx_hi_zero", 256'(p_wdata[31:8]), 256'(0));
          chk("sb_avail", 256'(sb_q.size() > 0), 256'(1));
          if (sb_q.size() > 0) chk("tx_byte", 256'(p_wdata[7:0]), 256'(sb_q.pop_front()));
          tx_log.push_back(p_wdata[7:0]);
          tx_gr = 1'b0; polls = 0; tx_done++;
        end else begin
          chk("legal_access", 256'({p_rd, p_wr, p_addr}), 256'({1'b1, 1'b0, 5'd8}));
        end
      end
      pend = 1'b0;
      chk("rd_wr_excl", 256'(avm_read & avm_write), 256'(0));
      if (!avm_read && !avm_write) chk("idle_addr", 256'(avm_address), 256'(8));
      if (o_core_start) begin
        starts++;
        chk("start_width", 256'(prev_start), 256'(0));
      end
      prev_start = o_core_start;
      if (avm_read || avm_write) begin
        if (hold) chk("req_stable", 256'({avm_read, avm_write, avm_address, avm_writedata}), 256'(held));
        if (wcnt < wait_cycles) begin
          // Stalled cycles return all-ones so a premature status/data sample is visible.
          avm_waitrequest = 1'b1;
          avm_readdata = 32'hFFFF_FFFF;
          wcnt++;
          hold = 1'b1;
          held = {avm_read, avm_write, avm_address, avm_writedata};
        end else begin
          avm_waitrequest = 1'b0;
          wcnt = 0; hold = 1'b0; pend = 1'b1;
          p_rd = avm_read; p_wr = avm_write; p_addr = avm_address; p_wdata = avm_writedata;
          if (avm_address == 5'd8)
            p_rdata = {24'h0, (rx_q.size() > 0) && (polls >= rx_delay), (polls >= tx_delay), 6'h0};
          else if (avm_address == 5'd0 && rx_q.size() > 0)
            p_rdata = {24'h0, rx_q[0]};
          else
            p_rdata = 32'h0;
          avm_readdata = p_rdata;
        end
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0;
        hold = 1'b0; wcnt = 0;
      end
    end
  end

  // RSA core: answers each start after CORE_LAT cycles; emits stray finish pulses when idle.
  initial begin
    int cnt, idle;
    logic busy;
    logic [255:0] snap_a, snap_b, res_v;
    cnt = 0; idle = 0; busy = 1'b0; snap_a = '0; snap_b = '0; res_v = CORE_RES;
    i_core_finished = 1'b0;
    i_core_result = '0;
    forever begin
      @(negedge clk);
      i_core_finished = 1'b0;
      if (!rst_q) begin
        busy = 1'b0; idle = 0;
      end else if (busy) begin
        cnt++;
        chk("a_stable", o_core_a, snap_a);
        chk("b_stable", o_core_b, snap_b);
        if (cnt == CORE_LAT) begin
          i_core_finished = 1'b1;
          i_core_result = res_v;
          busy = 1'b0;
          for (int k = 0; k < 31; k++) sb_q.push_back(res_v[247 - 8*k -: 8]);
        end
      end else if (o_core_start) begin
        busy = 1'b1; cnt = 0; snap_a = o_core_a; snap_b = o_core_b;
      end else begin
        idle++;
        if (idle % 37 == 0) begin
          i_core_finished = 1'b1;
          i_core_result = {8{32'hDEAD_BEEF}};
        end
      end
    end
  end

  task automatic wait_rx(input int target);
    for (int c = 0; c < 20000 && rx_done < target; c++) @(posedge clk);
    chk("rx_count", 256'(rx_done), 256'(target));
  endtask

  task automatic wait_tx(input int target);
    for (int c = 0; c < 20000 && tx_done < target; c++) @(posedge clk);
    chk("tx_wait", 256'(tx_done), 256'(target));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_read"}, 256'(avm_read), 256'(0));
    chk({tag, "_write"}, 256'(avm_write), 256'(0));
    chk({tag, "_addr"}, 256'(avm_address), 256'(8));
    chk({tag, "_wdata"}, 256'(avm_writedata), 256'(0));
    chk({tag, "_start"}, 256'(o_core_start), 256'(0));
    chk({tag, "_a"}, o_core_a, 256'(0));
    chk({tag, "_b"}, o_core_b, 256'(0));
    #1 i_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_first_rd"}, 256'(avm_read), 256'(1));
    chk({tag, "_first_addr"}, 256'(avm_address), 256'(8));
  endtask

  task automatic run_block(input string tag, input int mode, input logic [255:0] key);
    logic [255:0] blk;
    logic [7:0] b;
    int tx0, st0, rx0;
    tx0 = tx_done; st0 = starts; rx0 = rx_done; blk = '0;
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       b = 8'hAA;
        1:       b = 8'(i * 3 + 7);
        default: b = 8'($urandom);
      endcase
      rx_q.push_back(b);
      blk = {blk[247:0], b};
    end
    wait_tx(tx0 + 31);
    repeat (60) @(posedge clk);
    #1;
    chk({tag, "_rx_count"}, 256'(rx_done), 256'(rx0 + 32));
    chk({tag, "_tx_count"}, 256'(tx_done), 256'(tx0 + 31));
    if (tx_log.size() >= tx0 + 31) begin
      chk({tag, "_first"}, 256'(tx_log[tx0]), 256'(8'h00));
      chk({tag, "_last"}, 256'(tx_log[tx0 + 30]), 256'(8'hFF));
    end
    chk({tag, "_starts"}, 256'(starts), 256'(st0 + 1));
    chk({tag, "_sb_empty"}, 256'(sb_q.size()), 256'(0));
    chk({tag, "_a"}, o_core_a, key);
    chk({tag, "_b"}, o_core_b, blk);
  endtask

  initial begin
    logic [255:0] key;
    int rx0, st0;
    repeat (2) @(posedge clk);
    do_reset("rst0");

    // Key load
    key = '0;
    for (int i = 1; i <= 32; i++) begin
      rx_q.push_back(8'(i));
      key = {key[247:0], 8'(i)};
    end
    wait_rx(32);
    repeat (3) @(posedge clk);
    #1;
    chk("key_a", o_core_a, key);
    chk("key_b", o_core_b, 256'(0));
    chk("key_starts", 256'(starts), 256'(0));

    run_block("blk_aa", 0, key);

    wait_cycles = 5;
    run_block("blk_bp", 1, key);

    wait_cycles = 0; rx_delay = 20; tx_delay = 20;
    run_block("blk_poll", 2, key);

    // Reset in the middle of the 17th key byte
    rx_delay = 0; tx_delay = 0;
    do_reset("rst1");
    rx0 = rx_done;
    st0 = starts;
    for (int i = 0; i < 32; i++) rx_q.push_back(8'($urandom));
    wait_rx(rx0 + 16);
    do_reset("rst_mid");
    chk("rst_mid_starts", 256'(starts), 256'(st0));
    rx0 = rx_done;
    key = '0;
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      rx_q.push_back(b);
      key = {key[247:0], b};
    end
    wait_rx(rx0 + 32);
    repeat (30) @(posedge clk);
    #1;
    chk("rekey_a", o_core_a, key);
    chk("rekey_b", o_core_b, 256'(0));
    chk("rekey_starts", 256'(starts), 256'(st0));
    run_block("blk_rekey", 2, key);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa256_wrapper.md
RSA256_WRAPPER -- requirements
Module: rsa256_wrapper

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-low reset.
REQ-002 i_clk  in  1  sole clock; all state updates occur on its rising edge.
REQ-003 i_rst_n  in  1  synchronous active-low reset, sampled on the rising edge of i_clk.
REQ-004 avm_address  out  5  Avalon-MM word address to the RS232 UART.
- RX data = 0.
- TX data = 4.
- STATUS = 8.
REQ-005 avm_read  out  1  Avalon-MM read request.
REQ-006 avm_readdata  in  32  UART read data; bits [7:0] hold the byte, STATUS bit 7 = RX_OK, STATUS bit 6 = TX_OK.
REQ-007 avm_write  out  1  Avalon-MM write request.
REQ-008 avm_writedata  out  32  UART write data; bits [31:8] are always 0.
REQ-009 avm_waitrequest  in  1  slave stall; a transfer completes in the first cycle its request is high with waitrequest low.
REQ-010 o_core_start  out  1  single-cycle start pulse to the RSA core.
REQ-011 o_core_a  out  256  operand A (key), held stable while the core runs.
REQ-012 o_core_b  out  256  operand B (data block), held stable while the core runs.
REQ-013 i_core_finished  in  1  core completion pulse.
REQ-014 i_core_result  in  256  core result, valid in the cycle i_core_finished is high.

Function
REQ-015 States SHALL be:
- QRX: poll STATUS for receive.
- RX: read one byte.
- START: pulse the core.
- WAIT: wait for core completion.
- QTX: poll STATUS for transmit.
- TX: write one byte.
REQ-016 A 5-bit byte counter and a 1-bit key_loaded flag SHALL sequence the phases.
- Key phase: key_loaded=0.
- Data phase: key_loaded=1.
REQ-017 QRX: avm_read=1, avm_address=8.
- On a completed read with readdata[7]=1 -> RX.
- Otherwise stay in QRX with the read held asserted.
REQ-018 RX: avm_read=1, avm_address=0.
- On completion: the destination register (A if key_loaded=0, else B) SHALL shift as reg <= {reg[247:0], readdata[7:0]} (MSB byte first).
- Counter increments on each completed byte.
REQ-019 RX completion of the 32nd byte (counter=31):
- Counter clears.
- If key_loaded=0: set key_loaded=1 and go to QRX.
- Else: go to START.
REQ-020 RX completion of any other byte -> QRX.
REQ-021 START: o_core_start=1 for exactly one cycle, then WAIT.
REQ-022 WAIT: on i_core_finished=1, latch i_core_result into the TX shift register and go to QTX.
- o_core_a and o_core_b SHALL not change during START or WAIT.
REQ-023 QTX: avm_read=1, avm_address=8.
- On a completed read with readdata[6]=1 -> TX.
- Otherwise stay in QTX.
REQ-024 TX: avm_write=1, avm_address=4, avm_writedata={24'h0, txreg[247:240]}.
- On completion: txreg shifts left 8 bits and the counter increments.
REQ-025 Only 31 result bytes (bits [247:0], MSB first) SHALL be sent.
- Completion of the 31st byte (counter=30): counter clears, go to QRX.
- Data phase continues; key_loaded stays 1.
REQ-026 Completion of any other TX byte -> QTX.
REQ-027 avm_read and avm_write SHALL never be high in the same cycle.
REQ-028 A request SHALL stay asserted with constant address and data until waitrequest is sampled low.
REQ-029 In every state other than RX and TX, avm_address SHALL be 8.
REQ-030 i_core_finished arriving in any state other than WAIT SHALL be ignored.
REQ-031 RX_OK/TX_OK values returned while avm_waitrequest=1 SHALL be ignored.

Reset
REQ-032 With i_rst_n=0 at a clock edge, the following SHALL hold on the next cycle regardless of state, including mid-byte, mid-transfer, or during WAIT:
- state=QRX, counter=0, key_loaded=0.
- avm_read=0, avm_write=0, avm_address=8, avm_writedata=0.
- o_core_start=0, o_core_a=0, o_core_b=0, txreg=0.
REQ-033 After reset release, the first request (avm_read with address 8) SHALL be asserted in the cycle following the first edge with i_rst_n=1.

Verification
REQ-034 Key load: feed bytes 0x01..0x20 -> o_core_a=256'h0102...1F20, key_loaded=1, no o_core_start.
REQ-035 Block round-trip: 32 data bytes 0xAA, core model returns 256'h00112233...EEFF after 10 cycles.
- Exactly 31 TX writes, 0x00 first and 0xFF last.
- One o_core_start pulse.
REQ-036 Back-pressure: hold avm_waitrequest=1 for 5 cycles on every transfer.
- address and request stay stable.
- Exactly one shift per byte.
- Results identical to REQ-035.
REQ-037 Status polling: RX_OK=0 for 20 polls, then 1 -> no RX read until the RX_OK=1 poll completes.
- TX_OK=0 likewise blocks TX writes.
REQ-038 Second block: after REQ-035, send 32 more bytes -> o_core_a unchanged, o_core_b updated, second start pulse.
REQ-039 Reset mid-RX at byte 17 of the key -> all REQ-032 values.
- A full 32-byte key must then be resent before any start pulse.
